// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared state encoding and instruction-field constants for the fetch stage
package fetch_stage_pkg;
  typedef enum logic [1:0] {S_RUN = 2'd0, S_WAIT = 2'd1, S_DRAIN = 2'd2, S_HALTED = 2'd3} state_t;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;
  localparam logic [15:0] NOP_INSTR_DEF = 16'h0800;
  localparam logic [4:0] HALT_OPC_DEF = 5'b00000;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 11;
endpackage

// File: rtl/fetch_dff.sv
// fetch_dff: enabled register with synchronous active-high reset
module fetch_dff #(
  parameter int W = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= RST_VAL;
    else if (en) q <= d;
endmodule

// File: rtl/fetch_stage_pc_sel.sv
// fetch_pc_sel: next-pc mux choosing redirect target, pc+2 or hold
module fetch_pc_sel (
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  input  logic        advance,
  input  logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic [15:0] next_pc
);
  assign pc_plus2 = pc + 16'd2;
  assign next_pc = redirect_en ? {redirect_pc[15:1], 1'b0} : advance ? pc_plus2 : pc;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage owning the pc and imem request, with holdover buffer, redirect drain and halt
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEF,
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter logic [4:0]  HALT_OPC = HALT_OPC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  output logic        imem_rd_en,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  output logic        instr_valid,
  output logic [15:0] instruction_out,
  output logic [15:0] pc_next_out,
  output logic        halted,
  output logic        err_align
);
  logic [15:0] pc, pc_plus2, next_pc, buf_q, word;
  logic [1:0] state_q;
  state_t state, state_d;
  logic active, avail, deliver, halt_hit, buf_valid, buf_valid_d, buf_load, pending;
  assign state = state_t'(state_q);
  assign active = state == S_RUN || state == S_WAIT;
  assign imem_rd_en = !rst && active && !buf_valid;
  assign pending = imem_rd_en && !imem_done;
  assign avail = buf_valid || (imem_rd_en && imem_done);
  assign word = buf_valid ? buf_q : imem_data;
  assign deliver = !rst && !redirect_en && !stall && avail;
  assign halt_hit = deliver && word[OPC_MSB:OPC_LSB] == HALT_OPC;
  assign buf_load = imem_rd_en && imem_done && stall && !redirect_en;
  assign buf_valid_d = redirect_en ? 1'b0 : buf_load ? 1'b1 : deliver ? 1'b0 : buf_valid;
  // A redirect while a request is in flight must swallow that late completion
  always_comb begin
    state_d = state;
    if (redirect_en) state_d = state == S_DRAIN ? (imem_done ? S_RUN : S_DRAIN) : pending ? S_DRAIN : S_RUN;
    else if (state == S_DRAIN) state_d = imem_done ? S_RUN : S_DRAIN;
    else if (active) state_d = halt_hit ? S_HALTED : pending ? S_WAIT : S_RUN;
  end
  fetch_pc_sel u_pc_sel (
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .advance(deliver && !halt_hit),
    .pc(pc),
    .pc_plus2(pc_plus2),
    .next_pc(next_pc)
  );
  fetch_dff #(.W(16), .RST_VAL(RESET_PC)) u_pc (.clk(clk), .rst(rst), .en(1'b1), .d(next_pc), .q(pc));
  fetch_dff #(.W(2), .RST_VAL(S_RUN)) u_state (.clk(clk), .rst(rst), .en(1'b1), .d(state_d), .q(state_q));
  fetch_dff #(.W(16)) u_buf (.clk(clk), .rst(rst), .en(buf_load), .d(imem_data), .q(buf_q));
  fetch_dff #(.W(1)) u_buf_valid (.clk(clk), .rst(rst), .en(1'b1), .d(buf_valid_d), .q(buf_valid));
  fetch_dff #(.W(1)) u_err (.clk(clk), .rst(rst), .en(1'b1), .d(err_align | (redirect_en & redirect_pc[0])), .q(err_align));
  assign imem_addr = pc;
  assign instr_valid = deliver;
  assign instruction_out = deliver ? word : NOP_INSTR;
  assign pc_next_out = rst ? RESET_PC + 16'd2 : pc_plus2;
  assign halted = !rst && state == S_HALTED;
endmodule
